// File: rtl/cmul_scheduler_if.sv
// cmul_scheduler_if: operand/result handshakes plus the shared-multiplier port of cmul_scheduler.
interface cmul_scheduler_if;
  logic in_valid;
  logic in_ready;
  logic [15:0] a_re;
  logic [15:0] a_im;
  logic [15:0] w_re;
  logic [15:0] w_im;
  logic out_valid;
  logic out_ready;
  logic [15:0] y_re;
  logic [15:0] y_im;
  logic y_sat;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic mul_en;
  logic [31:0] mul_result;
  modport slave (
    input  in_valid, a_re, a_im, w_re, w_im, out_ready, mul_result,
    output in_ready, out_valid, y_re, y_im, y_sat, mul_a, mul_b, mul_en
  );
  modport master (
    output in_valid, a_re, a_im, w_re, w_im, out_ready, mul_result,
    input  in_ready, out_valid, y_re, y_im, y_sat, mul_a, mul_b, mul_en
  );
endinterface

// File: rtl/cmul_scheduler.sv
// cmul_scheduler: Q15 complex multiply through one shared unsigned 16x16 multiplier,
// four sign-magnitude partial products, then round, shift and saturate to 16 bits.
module cmul_scheduler #(
  parameter int SHIFT = 15,
  parameter bit ROUND = 1'b1
) (
  input logic clk,
  input logic rst_n,
  cmul_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;
  localparam logic signed [33:0] RND = ROUND ? (34'sd1 <<< (SHIFT - 1)) : 34'sd0;
  state_t state, next;
  logic [15:0] m_ar, m_ai, m_wr, m_wi;
  logic s_ar, s_ai, s_wr, s_wi;
  logic signed [32:0] re_acc, im_acc, mag, prod, im_sum;
  logic neg;
  logic [16:0] re_q, im_q;
  function automatic logic [15:0] abs16(input logic [15:0] x);
    return x[15] ? -x : x;
  endfunction
  // Returns {saturated, value}; the extra top bit keeps the rounding add from wrapping.
  function automatic logic [16:0] rnd_sat(input logic signed [32:0] v);
    logic signed [33:0] s;
    s = ($signed({v[32], v}) + RND) >>> SHIFT;
    return s > 34'sd32767 ? {1'b1, 16'h7fff} : s < -34'sd32768 ? {1'b1, 16'h8000} : {1'b0, s[15:0]};
  endfunction
  always_comb begin
    next = state == IDLE ? (bus.in_valid && bus.in_ready ? P0 : IDLE) :
           state == P0   ? P1 :
           state == P1   ? P2 :
           state == P2   ? P3 :
           state == P3   ? DONE :
           state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
    neg = state == P0 ? s_ar ^ s_wr :
          state == P1 ? s_ai ^ s_wi :
          state == P2 ? s_ar ^ s_wi : s_ai ^ s_wr;
    mag = $signed({1'b0, bus.mul_result});
    prod = neg ? -mag : mag;
    im_sum = im_acc + prod;
    re_q = rnd_sat(re_acc);
    im_q = rnd_sat(im_sum);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.y_re <= '0;
      bus.y_im <= '0;
      bus.y_sat <= 1'b0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      bus.mul_en <= 1'b0;
      m_ar <= '0;
      m_ai <= '0;
      m_wr <= '0;
      m_wi <= '0;
      s_ar <= 1'b0;
      s_ai <= 1'b0;
      s_wr <= 1'b0;
      s_wi <= 1'b0;
      re_acc <= '0;
      im_acc <= '0;
    end else begin
      state <= next;
      bus.in_ready <= (next == IDLE);
      case (state)
        IDLE: if (next == P0) begin
          m_ar <= abs16(bus.a_re);
          m_ai <= abs16(bus.a_im);
          m_wr <= abs16(bus.w_re);
          m_wi <= abs16(bus.w_im);
          s_ar <= bus.a_re[15];
          s_ai <= bus.a_im[15];
          s_wr <= bus.w_re[15];
          s_wi <= bus.w_im[15];
          bus.mul_a <= abs16(bus.a_re);
          bus.mul_b <= abs16(bus.w_re);
          bus.mul_en <= 1'b1;
          re_acc <= '0;
          im_acc <= '0;
        end
        P0: begin
          re_acc <= re_acc + prod;
          bus.mul_a <= m_ai;
          bus.mul_b <= m_wi;
        end
        P1: begin
          re_acc <= re_acc - prod;
          bus.mul_a <= m_ar;
          bus.mul_b <= m_wi;
        end
        P2: begin
          im_acc <= im_acc + prod;
          bus.mul_a <= m_ai;
          bus.mul_b <= m_wr;
        end
        P3: begin
          im_acc <= im_sum;
          bus.mul_a <= '0;
          bus.mul_b <= '0;
          bus.mul_en <= 1'b0;
          bus.y_re <= re_q[15:0];
          bus.y_im <= im_q[15:0];
          bus.y_sat <= re_q[16] | im_q[16];
          bus.out_valid <= 1'b1;
        end
        DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmul_scheduler.sv
// tb_cmul_scheduler: table vectors, hand-written corner sequences and random operands
// checked against a full-precision signed arithmetic model.
module tb_cmul_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  cmul_scheduler_if bus ();
  cmul_scheduler_if bus_t ();
  assign bus.mul_result = 32'(bus.mul_a) * 32'(bus.mul_b);
  assign bus_t.mul_result = 32'(bus_t.mul_a) * 32'(bus_t.mul_b);
  cmul_scheduler #(.SHIFT(15), .ROUND(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  cmul_scheduler #(.SHIFT(15), .ROUND(1'b0)) u_trunc (.clk(clk), .rst_n(rst_n), .bus(bus_t));
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    int ar, ai, wr, wi, yre, yim, sat;
  } vec_t;
  vec_t vecs [7];
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int iabs(input int x);
    return x < 0 ? -x : x;
  endfunction
  function automatic int clamp(input longint v, output int sat);
    sat = (v > 32767 || v < -32768) ? 1 : 0;
    return v > 32767 ? 32767 : v < -32768 ? -32768 : int'(v);
  endfunction
  function automatic void model(input int ar, ai, wr, wi, input bit rnd, output int yre, yim, sat);
    longint re, im;
    int s1, s2;
    re = longint'(ar) * wr - longint'(ai) * wi;
    im = longint'(ar) * wi + longint'(ai) * wr;
    if (rnd) begin
      re = re + 16384;
      im = im + 16384;
    end
    yre = clamp(re >>> 15, s1);
    yim = clamp(im >>> 15, s2);
    sat = s1 | s2;
  endfunction
  function automatic int rv();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? -32768 : r == 1 ? 32767 : int'($signed(16'($urandom)));
  endfunction
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready"}, longint'(bus.in_ready), 1);
  endtask
  task automatic apply(input int ar, ai, wr, wi);
    bus.a_re = 16'(ar);
    bus.a_im = 16'(ai);
    bus.w_re = 16'(wr);
    bus.w_im = 16'(wi);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic run_op(input string nm, input int ar, ai, wr, wi, yre, yim, sat);
    wait_ready(nm);
    bus.out_ready = 1'b1;
    apply(ar, ai, wr, wi);
    for (int k = 0; k < 4; k++) begin
      chk({nm, " mul_a"}, longint'(bus.mul_a), (k == 0 || k == 2) ? iabs(ar) : iabs(ai));
      chk({nm, " mul_b"}, longint'(bus.mul_b), (k == 0 || k == 3) ? iabs(wr) : iabs(wi));
      chk({nm, " mul_en"}, longint'(bus.mul_en), 1);
      @(negedge clk);
    end
    chk({nm, " out_valid"}, longint'(bus.out_valid), 1);
    chk({nm, " y_re"}, longint'($signed(bus.y_re)), yre);
    chk({nm, " y_im"}, longint'($signed(bus.y_im)), yim);
    chk({nm, " y_sat"}, longint'(bus.y_sat), sat);
    chk({nm, " mul_en idle"}, longint'(bus.mul_en), 0);
    @(negedge clk);
    chk({nm, " in_ready after"}, longint'(bus.in_ready), 1);
    chk({nm, " out_valid after"}, longint'(bus.out_valid), 0);
  endtask
  initial begin
    int yre, yim, sat, n;
    vecs[0] = '{"basic", 16384, 0, 32767, 0, 16384, 0, 0};
    vecs[1] = '{"imag_sq", 0, 16384, 0, 16384, -8192, 0, 0};
    vecs[2] = '{"mixed_signs", -16384, 8192, 16384, -16384, -4096, 12288, 0};
    vecs[3] = '{"sat_re", -32768, 0, -32768, 0, 32767, 0, 1};
    vecs[4] = '{"sat_both_neg", -32768, -32768, -32768, 32767, 32767, 1, 1};
    vecs[5] = '{"round_tiny", 1, 0, -1, 0, 0, 0, 0};
    vecs[6] = '{"zero", 0, 0, -32768, 32767, 0, 0, 0};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    {bus.a_re, bus.a_im, bus.w_re, bus.w_im} = '0;
    bus_t.in_valid = 1'b0;
    bus_t.out_ready = 1'b1;
    {bus_t.a_re, bus_t.a_im, bus_t.w_re, bus_t.w_im} = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", longint'(bus.in_ready), 0);
    chk("reset out_valid", longint'(bus.out_valid), 0);
    chk("reset y", longint'({bus.y_re, bus.y_im, bus.y_sat}), 0);
    chk("reset mul", longint'({bus.mul_a, bus.mul_b, bus.mul_en}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first in_ready", longint'(bus.in_ready), 1);
    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].ar, vecs[i].ai, vecs[i].wr, vecs[i].wi, vecs[i].yre, vecs[i].yim, vecs[i].sat);
    // Backpressure: result must hold and a second operand set must be ignored.
    wait_ready("bp");
    bus.out_ready = 1'b0;
    apply(100, 200, 300, -400);
    repeat (4) @(negedge clk);
    model(100, 200, 300, -400, 1'b1, yre, yim, sat);
    bus.a_re = 16'd7;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("bp out_valid", longint'(bus.out_valid), 1);
      chk("bp y_re", longint'($signed(bus.y_re)), yre);
      chk("bp y_im", longint'($signed(bus.y_im)), yim);
      chk("bp in_ready", longint'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", longint'(bus.in_ready), 1);
    chk("bp release out_valid", longint'(bus.out_valid), 0);
    // Reset during P2 abandons the operation.
    wait_ready("rst_mid");
    apply(1000, -2000, 3000, 4000);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid in_ready", longint'(bus.in_ready), 0);
    chk("rst_mid out_valid", longint'(bus.out_valid), 0);
    chk("rst_mid y", longint'({bus.y_re, bus.y_im, bus.y_sat}), 0);
    chk("rst_mid mul", longint'({bus.mul_a, bus.mul_b, bus.mul_en}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid release in_ready", longint'(bus.in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      chk("rst_mid no stale out_valid", longint'(bus.out_valid), 0);
      @(negedge clk);
    end
    model(1000, -2000, 3000, 4000, 1'b1, yre, yim, sat);
    run_op("rst_mid fresh", 1000, -2000, 3000, 4000, yre, yim, sat);
    // Truncating instance floors instead of rounding.
    n = 0;
    while (!bus_t.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("trunc in_ready", longint'(bus_t.in_ready), 1);
    bus_t.a_re = 16'd1;
    bus_t.w_re = 16'hffff;
    bus_t.in_valid = 1'b1;
    @(negedge clk);
    bus_t.in_valid = 1'b0;
    n = 0;
    while (!bus_t.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("trunc latency", n, 4);
    chk("trunc y_re", longint'($signed(bus_t.y_re)), -1);
    chk("trunc y_im", longint'($signed(bus_t.y_im)), 0);
    for (int t = 0; t < 60; t++) begin
      int ar, ai, wr, wi;
      ar = rv();
      ai = rv();
      wr = rv();
      wi = rv();
      model(ar, ai, wr, wi, 1'b1, yre, yim, sat);
      run_op($sformatf("rand%0d", t), ar, ai, wr, wi, yre, yim, sat);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
